// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: two-port (CPU / DMA) data-memory sequencer with alignment check, lane steering and slave timeout
module dm_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter bit          CPU_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic [2:0]  cpu_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_cancel,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dma_valid,
    input  logic [2:0]  dma_op,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CHECK, ACCESS, RESP} state_t;
    state_t      state;
    logic        last_grant, owner;
    logic [2:0]  op;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic [7:0]  cnt;
    logic        cpu_req, dma_req, pick_dma, word, half, store, misal;
    logic [3:0]  be;
    logic [31:0] wd;
    always_comb begin
        cpu_req  = cpu_valid & ~cpu_cancel & (cpu_op != 3'd0) & (cpu_op != 3'd7);
        dma_req  = dma_valid & (dma_op != 3'd0) & (dma_op != 3'd7);
        // owner/last_grant encoding: 1 = DMA
        pick_dma = dma_req & (~cpu_req | (~CPU_PRIO & ~last_grant));
        word     = (op == 3'd1) | (op == 3'd3);
        half     = (op == 3'd2) | (op == 3'd4);
        store    = (op == 3'd1) | (op == 3'd2) | (op == 3'd6);
        misal    = (word & (|addr[1:0])) | (half & addr[0]);
        be       = ~store ? 4'b0000 : word ? 4'b1111 : half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
        wd       = word ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op         <= '0;
            addr       <= '0;
            wdata      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                IDLE: if (cpu_req | dma_req) begin
                    owner      <= pick_dma;
                    last_grant <= pick_dma;
                    op         <= pick_dma ? dma_op : cpu_op;
                    addr       <= pick_dma ? dma_addr : cpu_addr;
                    wdata      <= pick_dma ? dma_wdata : cpu_wdata;
                    state      <= CHECK;
                end
                CHECK: if (misal) begin
                    err     <= 1'b1;
                    rdata   <= '0;
                    cpu_ack <= ~owner;
                    dma_ack <= owner;
                    state   <= RESP;
                end else begin
                    err       <= 1'b0;
                    cnt       <= '0;
                    mem_req   <= 1'b1;
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_be    <= be;
                    mem_wdata <= wd;
                    state     <= ACCESS;
                end
                ACCESS: if (mem_ready | (cnt == 8'(TIMEOUT - 1))) begin
                    rdata   <= mem_ready ? mem_rdata : '0;
                    err     <= ~mem_ready;
                    mem_req <= 1'b0;
                    cpu_ack <= ~owner;
                    dma_ack <= owner;
                    state   <= RESP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign cpu_rdata = owner ? '0 : rdata;
    assign dma_rdata = owner ? rdata : '0;
    assign cpu_err   = err & ~owner;
    assign dma_err   = err & owner;
    assign cpu_stall = cpu_valid & ~cpu_ack & ~cpu_cancel;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: directed vector table plus hand sequences for arbitration, timeout, cancel and reset
module tb_dm_bus_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        cpu_valid = 1'b0, cpu_cancel = 1'b0, dma_valid = 1'b0, mem_ready = 1'b0;
    logic [2:0]  cpu_op = '0, dma_op = '0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0, mem_rdata = '0;
    logic        cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err, mem_req, busy;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int checks = 0, errors = 0;

    dm_bus_arbiter #(.TIMEOUT(16), .CPU_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_cancel(cpu_cancel), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_op(dma_op), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wdata, rd;
        logic [3:0]  be;
        logic [31:0] mwd, exp_rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        logic seen_req = 1'b0, got = 1'b0, dma_seen = 1'b0;
        logic [3:0] be = '0;
        logic [31:0] wd = '0, ma = '0, rd = '0;
        logic e = 1'b0;
        int n = 0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = v.op; cpu_addr = v.addr; cpu_wdata = v.wdata;
        mem_rdata = v.rd; mem_ready = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (dma_ack) dma_seen = 1'b1;
            if (mem_req) begin seen_req = 1'b1; be = mem_be; wd = mem_wdata; ma = mem_addr; end
            if (cpu_ack) begin got = 1'b1; rd = cpu_rdata; e = cpu_err; end
        end
        cpu_valid = 1'b0;
        chk($sformatf("v%0d latency", idx), got ? n : -1, v.lat);
        chk($sformatf("v%0d rdata", idx), rd, v.exp_rd);
        chk($sformatf("v%0d err", idx), 32'(e), 32'(v.err));
        chk($sformatf("v%0d mem_req", idx), 32'(seen_req), 32'(!v.err));
        chk($sformatf("v%0d dma_ack", idx), 32'(dma_seen), 0);
        if (!v.err) begin
            chk($sformatf("v%0d be", idx), 32'(be), 32'(v.be));
            chk($sformatf("v%0d addr", idx), ma, {v.addr[31:2], 2'b00});
            if (v.be != 4'b0000) chk($sformatf("v%0d wdata", idx), wd, v.mwd);
        end
    endtask

    initial begin
        int n, k, both, reqcnt, lat;
        logic order[6];
        logic got;
        logic [31:0] rd;
        logic e;
        //          op    addr          wdata         rd            be       mwd           exp_rd        err lat
        tbl[0]  = '{3'd3, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 4'b0000, 32'h0,        32'hDEAD_BEEF, 0, 3};
        tbl[1]  = '{3'd6, 32'h0000_2003, 32'h0000_00A5, 32'h1111_1111, 4'b1000, 32'hA5A5_A5A5, 32'h1111_1111, 0, 3};
        tbl[2]  = '{3'd2, 32'h0000_2002, 32'h0000_1234, 32'h2222_2222, 4'b1100, 32'h1234_1234, 32'h2222_2222, 0, 3};
        tbl[3]  = '{3'd1, 32'h0000_2000, 32'hCAFE_F00D, 32'h3333_3333, 4'b1111, 32'hCAFE_F00D, 32'h3333_3333, 0, 3};
        tbl[4]  = '{3'd6, 32'h0000_2001, 32'hFFFF_FF7E, 32'h0,        4'b0010, 32'h7E7E_7E7E, 32'h0,        0, 3};
        tbl[5]  = '{3'd2, 32'h0000_2000, 32'hABCD_5678, 32'h0,        4'b0011, 32'h5678_5678, 32'h0,        0, 3};
        tbl[6]  = '{3'd3, 32'h0000_2002, 32'h0,        32'h4444_4444, 4'b0000, 32'h0,        32'h0,        1, 2};
        tbl[7]  = '{3'd4, 32'h0000_2001, 32'h0,        32'h5555_5555, 4'b0000, 32'h0,        32'h0,        1, 2};
        tbl[8]  = '{3'd4, 32'h0000_2002, 32'h0,        32'h8765_4321, 4'b0000, 32'h0,        32'h8765_4321, 0, 3};
        tbl[9]  = '{3'd5, 32'h0000_2003, 32'h0,        32'h0F0F_0F0F, 4'b0000, 32'h0,        32'h0F0F_0F0F, 0, 3};
        tbl[10] = '{3'd1, 32'h0000_2001, 32'h9999_9999, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 2};

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset acks", {30'b0, cpu_ack, dma_ack}, 0);
        chk("reset mem_be", 32'(mem_be), 0);
        chk("reset cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;

        // both ports continuously valid: CPU first after reset, then alternate
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 3'd3; cpu_addr = 32'h100;
        dma_valid = 1'b1; dma_op = 3'd3; dma_addr = 32'h200;
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        k = 0; both = 0; n = 0;
        while (k < 6 && n < 60) begin
            @(negedge clk);
            n++;
            if (cpu_ack && dma_ack) both++;
            if (cpu_ack) begin order[k] = 1'b0; k++; chk("alt cpu_rdata", cpu_rdata, 32'h5555_AAAA); end
            else if (dma_ack) begin order[k] = 1'b1; k++; chk("alt dma_rdata", dma_rdata, 32'h5555_AAAA); end
        end
        cpu_valid = 1'b0; dma_valid = 1'b0;
        chk("alt count", k, 6);
        for (int i = 0; i < 6; i++) chk($sformatf("alt grant %0d", i), 32'(order[i]), 32'(i % 2));
        chk("alt dual ack", both, 0);

        for (int i = 0; i < 11; i++) run(tbl[i], i);

        // cancel while idle: no grant, no stall
        @(negedge clk);
        cpu_valid = 1'b1; cpu_cancel = 1'b1; cpu_op = 3'd3; cpu_addr = 32'h300;
        #1 chk("cancel stall", 32'(cpu_stall), 0);
        repeat (3) @(negedge clk);
        chk("cancel busy", 32'(busy), 0);
        chk("cancel mem_req", 32'(mem_req), 0);
        cpu_valid = 1'b0; cpu_cancel = 1'b0;

        // cancel and valid drop after grant: access still completes
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 3'd3; cpu_addr = 32'h400; mem_ready = 1'b1; mem_rdata = 32'h600D_600D;
        @(negedge clk);
        cpu_valid = 1'b0; cpu_cancel = 1'b1;
        got = 1'b0; n = 1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin got = 1'b1; rd = cpu_rdata; end
        end
        cpu_cancel = 1'b0;
        chk("late cancel latency", got ? n : -1, 3);
        chk("late cancel rdata", rd, 32'h600D_600D);

        // slave never ready: timeout after 16 ACCESS cycles
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 3'd3; cpu_addr = 32'h500; mem_ready = 1'b0; mem_rdata = 32'hBAD0_BAD0;
        got = 1'b0; n = 0; reqcnt = 0; lat = -1; rd = '1; e = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_req) reqcnt++;
            if (n == 5) begin
                chk("timeout stall", 32'(cpu_stall), 1);
                chk("timeout busy", 32'(busy), 1);
            end
            if (cpu_ack) begin got = 1'b1; lat = n; rd = cpu_rdata; e = cpu_err; end
        end
        cpu_valid = 1'b0;
        chk("timeout req cycles", reqcnt, 16);
        chk("timeout latency", lat, 18);
        chk("timeout err", 32'(e), 1);
        chk("timeout rdata", rd, 0);

        // reset during ACCESS
        @(negedge clk);
        cpu_valid = 1'b1; cpu_op = 3'd3; cpu_addr = 32'h600; mem_ready = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin @(negedge clk); n++; end
        chk("pre-reset mem_req", 32'(mem_req), 1);
        cpu_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid reset mem_req", 32'(mem_req), 0);
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset ack", 32'(cpu_ack), 0);
        @(negedge clk);
        reset = 1'b0;
        run(tbl[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
